cordic_post_stage: RTL

- Output stage placed directly downstream of the last CORDIC_elemet in the rotation pipeline. It consumes x_k1/y_k1/z_k1 from the final stage.
- It re-aligns a valid flag and a quadrant tag to the pipeline data, removes the CORDIC gain from x/y, and applies quadrant correction.
- Results are buffered in a small FIFO so that downstream logic can apply ready/valid back-pressure; the rotation pipeline itself never stalls.

---
 rtl/cordic_post_stage.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cordic_post_stage.sv
// -----------------------------------------------------------------------------
// cordic_post_stage
//
// Output stage that sits directly after the last CORDIC rotation element.
// It re-aligns the sample-valid flag and quadrant tag with the final-stage
// data, removes the CORDIC gain from x/y (multiply by K ~= 0.60725 using a
// shift-add network), applies the quadrant correction, and buffers results
// in a small FIFO so downstream logic can apply ready/valid back-pressure.
// The rotation pipeline itself never stalls. If the FIFO is full and no pop
// happens, the new word is dropped and a sticky overflow flag is raised.
//
// Ports:
//   CLK        in   processing clock, all state updates on posedge
//   RESET      in   synchronous active-low reset
//   in_valid   in   sample enters rotation stage 0 this cycle
//   q_tag      in   [1:0] quadrant tag of that sample
//   x_in       in   [VALUE_WIDTH-1:0] final-stage x (two's complement)
//   y_in       in   [VALUE_WIDTH-1:0] final-stage y (two's complement)
//   z_in       in   [VALUE_WIDTH-1:0] final-stage residual angle
//   out_ready  in   downstream accepts the FIFO head this cycle
//   out_valid  out  FIFO head is valid
//   x_out      out  [VALUE_WIDTH-1:0] corrected, gain-compensated x
//   y_out      out  [VALUE_WIDTH-1:0] corrected, gain-compensated y
//   z_out      out  [VALUE_WIDTH-1:0] residual angle, passed through
//   overflow   out  sticky: a result was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module cordic_post_stage #(
    parameter int VALUE_WIDTH = 14,
    parameter int LATENCY     = 13,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   in_valid,
    input  logic [1:0]             q_tag,
    input  logic [VALUE_WIDTH-1:0] x_in,
    input  logic [VALUE_WIDTH-1:0] y_in,
    input  logic [VALUE_WIDTH-1:0] z_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [VALUE_WIDTH-1:0] x_out,
    output logic [VALUE_WIDTH-1:0] y_out,
    output logic [VALUE_WIDTH-1:0] z_out,
    output logic                   overflow
);

    localparam int SUM_WIDTH = VALUE_WIDTH + 3;
    localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam logic [VALUE_WIDTH-1:0] VAL_MAX  = {1'b0, {(VALUE_WIDTH-1){1'b1}}};
    localparam logic [VALUE_WIDTH-1:0] VAL_MIN  = {1'b1, {(VALUE_WIDTH-1){1'b0}}};
    localparam logic [VALUE_WIDTH-1:0] VAL_ONE  = {{(VALUE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]   CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0]   PTR_ONE  = PTR_WIDTH'(1);

    // Gain removal: v*K ~= (v>>>1)+(v>>>3)-(v>>>6)-(v>>>9)-(v>>>13), with
    // floor shifts, summed in three extra bits and clamped to the signed range.
    function automatic logic [VALUE_WIDTH-1:0] gain_comp(input logic [VALUE_WIDTH-1:0] v);
        logic signed [SUM_WIDTH-1:0] ext_s;
        logic signed [SUM_WIDTH-1:0] sum_s;
        ext_s = $signed({{3{v[VALUE_WIDTH-1]}}, v});
        sum_s = (ext_s >>> 4'd1) + (ext_s >>> 4'd3) - (ext_s >>> 4'd6)
              - (ext_s >>> 4'd9) - (ext_s >>> 4'd13);
        if (sum_s > $signed({3'b000, VAL_MAX})) begin
            gain_comp = VAL_MAX;
        end else if (sum_s < $signed({3'b111, VAL_MIN})) begin
            gain_comp = VAL_MIN;
        end else begin
            gain_comp = sum_s[VALUE_WIDTH-1:0];
        end
    endfunction

    // Two's complement negation; the most negative value clamps to the most
    // positive one instead of wrapping back onto itself.
    function automatic logic [VALUE_WIDTH-1:0] neg_sat(input logic [VALUE_WIDTH-1:0] v);
        if (v == VAL_MIN) begin
            neg_sat = VAL_MAX;
        end else begin
            neg_sat = ~v + VAL_ONE;
        end
    endfunction

    // ---------------------------------------------------------------- alignment
    logic [LATENCY-1:0]      vld_dly_r;
    logic [LATENCY-1:0][1:0] tag_dly_r;

    // Valid/tag delay line matching the rotation pipeline depth.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            vld_dly_r <= '0;
            tag_dly_r <= '0;
        end else begin
            vld_dly_r <= {vld_dly_r[LATENCY-2:0], in_valid};
            tag_dly_r <= {tag_dly_r[LATENCY-2:0], q_tag};
        end
    end

    // ---------------------------------------------------------------- stage G
    logic                   g_valid_r;
    logic [1:0]             g_tag_r;
    logic [VALUE_WIDTH-1:0] g_x_r;
    logic [VALUE_WIDTH-1:0] g_y_r;
    logic [VALUE_WIDTH-1:0] g_z_r;

    // Capture final-stage data when the delayed valid lines up, removing gain.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            g_valid_r <= 1'b0;
            g_tag_r   <= 2'b00;
            g_x_r     <= '0;
            g_y_r     <= '0;
            g_z_r     <= '0;
        end else begin
            g_valid_r <= vld_dly_r[LATENCY-1];
            if (vld_dly_r[LATENCY-1]) begin
                g_tag_r <= tag_dly_r[LATENCY-1];
                g_x_r   <= gain_comp(x_in);
                g_y_r   <= gain_comp(y_in);
                g_z_r   <= z_in;
            end
        end
    end

    // ---------------------------------------------------------------- stage C
    logic [VALUE_WIDTH-1:0] corr_x_s;
    logic [VALUE_WIDTH-1:0] corr_y_s;
    logic                   c_valid_r;
    logic [VALUE_WIDTH-1:0] c_x_r;
    logic [VALUE_WIDTH-1:0] c_y_r;
    logic [VALUE_WIDTH-1:0] c_z_r;

    // Quadrant correction: rotate the result back by the tagged multiple of 90 degrees.
    always_comb begin
        corr_x_s = g_x_r;
        corr_y_s = g_y_r;
        case (g_tag_r)
            2'b00: begin
                corr_x_s = g_x_r;
                corr_y_s = g_y_r;
            end
            2'b01: begin
                corr_x_s = neg_sat(g_y_r);
                corr_y_s = g_x_r;
            end
            2'b10: begin
                corr_x_s = neg_sat(g_x_r);
                corr_y_s = neg_sat(g_y_r);
            end
            2'b11: begin
                corr_x_s = g_y_r;
                corr_y_s = neg_sat(g_x_r);
            end
            default: begin
                corr_x_s = g_x_r;
                corr_y_s = g_y_r;
            end
        endcase
    end

    // Register the corrected word ahead of the FIFO write.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            c_valid_r <= 1'b0;
            c_x_r     <= '0;
            c_y_r     <= '0;
            c_z_r     <= '0;
        end else begin
            c_valid_r <= g_valid_r;
            if (g_valid_r) begin
                c_x_r <= corr_x_s;
                c_y_r <= corr_y_s;
                c_z_r <= g_z_r;
            end
        end
    end

    // ---------------------------------------------------------------- FIFO
    logic [VALUE_WIDTH-1:0] x_mem_r [FIFO_DEPTH];
    logic [VALUE_WIDTH-1:0] y_mem_r [FIFO_DEPTH];
    logic [VALUE_WIDTH-1:0] z_mem_r [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_r;
    logic [PTR_WIDTH-1:0]   rd_ptr_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic [CNT_WIDTH-1:0]   count_nxt_s;
    logic                   out_valid_r;
    logic                   overflow_r;
    logic                   full_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   drop_s;

    // Handshake decode: a pop frees a slot on the same edge, so full+pop still accepts a write.
    always_comb begin
        full_s  = (count_r == CNT_FULL);
        pop_s   = out_valid_r & out_ready;
        push_s  = c_valid_r & (~full_s | pop_s);
        drop_s  = c_valid_r & full_s & ~pop_s;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers, occupancy, head-valid and sticky overflow.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                x_mem_r[i] <= '0;
                y_mem_r[i] <= '0;
                z_mem_r[i] <= '0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (push_s) begin
                x_mem_r[wr_ptr_r] <= c_x_r;
                y_mem_r[wr_ptr_r] <= c_y_r;
                z_mem_r[wr_ptr_r] <= c_z_r;
                wr_ptr_r          <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
            overflow_r  <= overflow_r | drop_s;
        end
    end

    assign out_valid = out_valid_r;
    assign overflow  = overflow_r;
    assign x_out     = x_mem_r[rd_ptr_r];
    assign y_out     = y_mem_r[rd_ptr_r];
    assign z_out     = z_mem_r[rd_ptr_r];

endmodule
